demux4_buf: RTL and testbench
=============================

# demux4_buf

Buffered 1-to-4 demultiplexer: routes a single valid/ready input stream to one of four output channels selected per word, each output holding one word in a registered one-entry buffer. It is the distribution counterpart of the datapath select muxes. It serves wherever one producer (e.g. a result or write-back bus) must feed one of four consumers that may stall independently. All outputs are registered; input-side readiness is the only combinational path.

## Interface
- WIDTH, 8, data width of input and of each output channel

- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  input word present
- in_ready  output  1  block can accept the input word this cycle
- in_sel  input  2  destination channel (0..3) for the current input word
- in_data  input  WIDTH  input word
- out_valid  output  4  bit i: channel i buffer holds a word
- out_ready  input  4  bit i: consumer i takes the word this cycle
- out_data0..out_data3  output  WIDTH each  channel buffer contents
- busy  output  1  OR of out_valid

## Operation
- Per channel i: buffer register buf_i[WIDTH-1:0] and full flag full_i; out_valid[i] = full_i, out_data_i = buf_i.
- in_ready = ~full[in_sel] | out_ready[in_sel]. It depends only on the addressed channel; other channels' state never blocks the input.
- Accept = in_valid & in_ready. On accept, buf[in_sel] <= in_data and full[in_sel] <= 1 at the next edge.
- Drain_i = full_i & out_ready[i]. On drain without a same-channel accept, full_i <= 0 at the next edge. buf_i keeps its last value; it is not cleared.
- Simultaneous drain and accept on the same channel: the old word leaves and the new word loads. full_i stays 1, with no bubble.
- Simultaneous drain on channel j and accept on channel k≠j are independent.
- in_sel is ignored when in_valid=0. in_data and in_sel must be stable while in_valid=1 and in_ready=0; the block does not check this.
- Inputs held across consecutive accepted cycles produce one word per cycle into the selected channel while its consumer keeps out_ready=1.
- out_ready[i] while full_i=0 has no effect.

## Timing
- Reset (rstn=0, asynchronous): full_0..3=0, buf_0..3=0. Hence out_valid=4'b0000, out_data*=0, busy=0, and in_ready=1 for any in_sel.
- Deassertion of rstn is synchronous to the design, with no accept in the reset cycle.
- Latency: a word accepted at edge N is visible with out_valid[i]=1 and out_data_i=word after edge N. The earliest the consumer can take it is the cycle after edge N.
- Throughput: 1 word/cycle per channel when its consumer is always ready; aggregate 1 word/cycle.
- Full channel with out_ready[i]=0: in_ready=0 while in_sel=i. The word and out_valid hold indefinitely.
- Reset mid-operation: buffered words are discarded and all channels become empty immediately, without waiting for a clock edge.
- Combinational paths: out_ready → in_ready and in_sel → in_ready only. No path exists from in_data or in_valid to any output.

## Test plan
- Reset: hold rstn=0 with random inputs → out_valid=0000, all out_data=0, busy=0, in_ready=1. Release rstn, then drive in_valid=1, in_sel=2, in_data=8'hA5 → after one edge out_valid=0100, out_data2=A5, busy=1.
- Backpressure: channel 1 full with 8'h11, out_ready=0000, in_sel=1, in_data=8'h22 → in_ready=0 for 5 cycles and out_data1 stays 11. Raise out_ready[1] → in_ready=1, and after the edge out_data1=22 with out_valid[1] still 1.
- Independence: channel 0 full and stalled, then send 8'h33 to channel 3 → in_ready=1, and after the edge out_valid=1001 with out_data0 unchanged.
- Streaming: out_ready=1111, send 8 consecutive words 0..7 with in_sel=i%4 → each word appears on channel i%4 exactly one cycle after acceptance, with no stall cycles.
- Drain and hold: channel 2 holds 8'h5A with out_ready[2]=1 and in_valid=0 → after the edge out_valid[2]=0 and out_data2 still 5A.
- Async reset mid-stream: assert rstn=0 between clock edges with channels 0 and 3 full → out_valid becomes 0000 and buffers become 0 before the next edge. No stale word appears after release.

Source files
------------

// File: rtl/demux4_buf_if.sv
// Handshake bundle for demux4_buf: one valid/ready input stream with a
// per-word channel select, and four registered valid/ready output channels.
interface demux4_buf_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] in_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;
  logic             busy;

  // Producer/consumer side: drives the input word and the consumers' ready.
  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, busy
  );

  // Demultiplexer side.
  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, busy
  );
endinterface

// File: rtl/demux4_buf.sv
// Buffered 1-to-4 demultiplexer. Each output channel owns a one-entry
// registered buffer; the input is ready whenever the addressed channel is
// empty or is being drained in the same cycle, so a channel whose consumer
// is always ready sustains one word per cycle with no bubble.
module demux4_buf #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rstn,
  demux4_buf_if.slave  bus
);

  logic [3:0]       full_q, full_d;
  logic [WIDTH-1:0] buf_q [4];
  logic [WIDTH-1:0] buf_d [4];
  logic [3:0]       drain;
  logic             in_rdy;
  logic             accept;

  // Readiness looks only at the addressed channel; other channels never block.
  assign in_rdy = ~full_q[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign accept = bus.in_valid & in_rdy;
  assign drain  = full_q & bus.out_ready;

  // Next-state: drains empty their channel, an accept (re)fills the addressed
  // one; accept wins over drain so a same-channel swap keeps the flag set.
  always_comb begin
    full_d = full_q & ~drain;
    for (int i = 0; i < 4; i++) begin
      buf_d[i] = buf_q[i];
    end
    if (accept) begin
      full_d[bus.in_sel] = 1'b1;
      buf_d[bus.in_sel]  = bus.in_data;
    end
  end

  // Channel state; reset empties every buffer immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_q <= '0;
      for (int i = 0; i < 4; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      full_q <= full_d;
      for (int i = 0; i < 4; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = full_q;
  assign bus.out_data0 = buf_q[0];
  assign bus.out_data1 = buf_q[1];
  assign bus.out_data2 = buf_q[2];
  assign bus.out_data3 = buf_q[3];
  assign bus.busy      = |full_q;

endmodule

// File: tb/tb_demux4_buf.sv
// Bench for demux4_buf: directed stimulus pushes each accepted word into a
// per-channel expected queue; a monitor pops and compares on every drain.
module tb_demux4_buf;

  logic clk;
  logic rstn;

  demux4_buf_if #(.WIDTH(8)) bus ();

  demux4_buf #(.WIDTH(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int passed;
  logic [7:0] expq [4][$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [7:0] od(input int i);
    case (i)
      0:       od = bus.out_data0;
      1:       od = bus.out_data1;
      2:       od = bus.out_data2;
      default: od = bus.out_data3;
    endcase
  endfunction

  // Step to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a word and record it as expected on its channel (accept follows).
  task automatic offer(input logic [1:0] sel, input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = d;
    expq[sel].push_back(d);
  endtask

  // Monitor: every drain seen mid-cycle must match the oldest expected word.
  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.out_valid[i] && bus.out_ready[i]) begin
          if (expq[i].size() == 0) begin
            chk($sformatf("drain_unexpected_ch%0d", i), 32'(od(i)), 32'hFFFF_FFFF);
          end else begin
            chk($sformatf("drain_data_ch%0d", i), 32'(od(i)), 32'(expq[i].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    checks = 0;
    passed = 0;
    rstn = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sel = 2'd0;
    bus.in_data = 8'h00;
    bus.out_ready = 4'b0000;

    // Reset with random inputs
    for (int c = 0; c < 3; c++) begin
      bus.in_valid  = 1'($urandom);
      bus.in_data   = 8'($urandom);
      bus.out_ready = 4'($urandom);
      for (int s = 0; s < 4; s++) begin
        bus.in_sel = 2'(s);
        #1;
        chk($sformatf("rst_in_ready_sel%0d", s), 32'(bus.in_ready), 32'd1);
      end
      step();
    end
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_out_data%0d", i), 32'(od(i)), 32'h0);

    rstn = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 4'b0000;
    step();

    // First word to channel 2
    offer(2'd2, 8'hA5);
    #1 chk("first_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("first_out_valid", 32'(bus.out_valid), 32'b0100);
    chk("first_out_data2", 32'(bus.out_data2), 32'hA5);
    chk("first_busy", 32'(bus.busy), 32'd1);
    bus.out_ready = 4'b0100;
    step();
    bus.out_ready = 4'b0000;
    chk("first_drained", 32'(bus.out_valid), 32'b0000);

    // Backpressure on channel 1
    offer(2'd1, 8'h11);
    step();
    bus.in_valid = 1'b1;
    bus.in_sel = 2'd1;
    bus.in_data = 8'h22;
    for (int c = 0; c < 5; c++) begin
      #1 chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      step();
      chk("bp_hold_data1", 32'(bus.out_data1), 32'h11);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'b0010);
    end
    bus.out_ready = 4'b0010;
    #1 chk("bp_in_ready_high", 32'(bus.in_ready), 32'd1);
    expq[1].push_back(8'h22);
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 4'b0000;
    chk("bp_swap_valid1", 32'(bus.out_valid[1]), 32'd1);
    chk("bp_swap_data1", 32'(bus.out_data1), 32'h22);
    bus.out_ready = 4'b1111;
    step();
    bus.out_ready = 4'b0000;

    // Independence: channel 0 stalled, channel 3 still accepts
    offer(2'd0, 8'h44);
    step();
    bus.in_valid = 1'b1;
    bus.in_sel = 2'd0;
    #1 chk("ind_ch0_blocked", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    offer(2'd3, 8'h33);
    #1 chk("ind_ch3_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("ind_out_valid", 32'(bus.out_valid), 32'b1001);
    chk("ind_out_data0", 32'(bus.out_data0), 32'h44);
    chk("ind_out_data3", 32'(bus.out_data3), 32'h33);

    // Async reset mid-cycle with channels 0 and 3 full
    #3;
    rstn = 1'b0;
    for (int i = 0; i < 4; i++) expq[i].delete();
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_busy", 32'(bus.busy), 32'h0);
    chk("arst_out_data0", 32'(bus.out_data0), 32'h0);
    chk("arst_out_data3", 32'(bus.out_data3), 32'h0);
    step();
    rstn = 1'b1;
    bus.out_ready = 4'b1111;
    step();
    step();
    chk("arst_no_stale", 32'(bus.out_valid), 32'h0);

    // Streaming: 8 words round-robin, consumers always ready
    for (int k = 0; k < 8; k++) begin
      offer(2'(k % 4), 8'(k));
      #1 chk($sformatf("stream_ready_%0d", k), 32'(bus.in_ready), 32'd1);
      step();
      chk($sformatf("stream_valid_%0d", k), 32'(bus.out_valid[k % 4]), 32'd1);
      chk($sformatf("stream_data_%0d", k), 32'(od(k % 4)), 32'(k));
    end
    bus.in_valid = 1'b0;
    step();
    chk("stream_empty", 32'(bus.out_valid), 32'h0);
    bus.out_ready = 4'b0000;

    // Drain and hold on channel 2
    offer(2'd2, 8'h5A);
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 4'b0100;
    step();
    bus.out_ready = 4'b0000;
    chk("dh_valid2", 32'(bus.out_valid[2]), 32'd0);
    chk("dh_data2", 32'(bus.out_data2), 32'h5A);
    step();

    for (int i = 0; i < 4; i++) chk($sformatf("queue_empty_ch%0d", i), 32'(expq[i].size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
